// File: rtl/sqrt_arb_pkg.sv
// Shared types and widths for the round-robin square-root arbiter.
package sqrt_arb_pkg;

    localparam int SQ_IN_W   = 8;
    localparam int SQ_OUT_W  = 16;
    localparam int SQ_FRAC_W = 8;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/sqrt_arbiter_rr_grant.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_grant #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int sel;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sel   = 0;
        for (int k = 0; k < N; k++) begin
            sel = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[sel]) begin
                any_o      = 1'b1;
                gnt_o[sel] = 1'b1;
                idx_o      = IDX_W'(sel);
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one combinational sqrt datapath among N_REQ requesters, round-robin,
// holding the operand for SETTLE_CYC cycles before capturing the 8.8 result.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int SETTLE_CYC = 1,
    parameter int ID_W       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [SQ_IN_W*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [SQ_IN_W-1:0]         sqrt_in_o,
    input  logic [SQ_OUT_W-1:0]        sqrt_out_i,
    output logic                       rsp_valid_o,
    output logic [SQ_OUT_W-1:0]        rsp_data_o,
    output logic [ID_W-1:0]            rsp_id_o,
    input  logic                       rsp_ready_i,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           ops_cnt_o
);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SQ_IN_W-1:0]    sqrt_in_q, sqrt_in_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [SQ_OUT_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]      ops_q, ops_d;

    logic [N_REQ-1:0]      gnt;
    logic [ID_W-1:0]       gnt_idx;
    logic                  gnt_any;

    rr_grant #(.N(N_REQ), .IDX_W(ID_W)) u_rr_grant (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        sqrt_in_d   = sqrt_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        ops_d       = ops_q;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                // The grant vector only ever selects a valid requester, so any grant is a handshake.
                req_ready_o = gnt;
                if (gnt_any) begin
                    sqrt_in_d = req_data_i[int'(gnt_idx)*SQ_IN_W +: SQ_IN_W];
                    rsp_id_d  = gnt_idx;
                    rr_ptr_d  = (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + ID_W'(1);
                    cnt_d     = 4'(SETTLE_CYC-1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = sqrt_out_i;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (ops_q != '1) ops_d = ops_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            sqrt_in_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            sqrt_in_q   <= sqrt_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            ops_q       <= ops_d;
        end
    end

    assign sqrt_in_o   = sqrt_in_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign busy_o      = (state_q != IDLE);
    assign ops_cnt_o   = ops_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_sqrt_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic [7:0]  sqrt_in;
    logic [15:0] sqrt_out;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_ready;
    logic        busy;
    logic [15:0] ops_cnt;

    logic [3:0]  v4;
    logic [31:0] d4;
    logic [3:0]  ready4;
    logic [7:0]  sin4;
    logic [15:0] sout4;
    logic        rv4;
    logic [15:0] rd4;
    logic [1:0]  rid4;
    logic        rr4;
    logic        busy4;
    logic [15:0] ops4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // floor(sqrt(x)*256) == isqrt(x*65536)
    function automatic logic [15:0] sq(input logic [7:0] x);
        int v, r, t;
        v = int'(x) << 16;
        r = 0;
        for (int b = 11; b >= 0; b--) begin
            t = r | (1 << b);
            if (t * t <= v) r = t;
        end
        return 16'(r);
    endfunction

    assign sqrt_out = sq(sqrt_in);
    assign sout4    = sq(sin4);

    sqrt_arbiter #(.N_REQ(4), .SETTLE_CYC(1), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .sqrt_in_o(sqrt_in), .sqrt_out_i(sqrt_out),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_id_o(rsp_id),
        .rsp_ready_i(rsp_ready), .busy_o(busy), .ops_cnt_o(ops_cnt)
    );

    sqrt_arbiter #(.N_REQ(4), .SETTLE_CYC(4), .ID_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(v4), .req_data_i(d4),
        .req_ready_o(ready4), .sqrt_in_o(sin4), .sqrt_out_i(sout4),
        .rsp_valid_o(rv4), .rsp_data_o(rd4), .rsp_id_o(rid4),
        .rsp_ready_i(rr4), .busy_o(busy4), .ops_cnt_o(ops4)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // per-requester operand queues; a requester holds valid while its queue is non-empty
    logic [7:0] q0[$], q1[$], q2[$], q3[$];

    task automatic qpush(input int i, input logic [7:0] d);
        case (i)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [7:0] qfront(input int i);
        case (i)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    task automatic qpop(input int i);
        case (i)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = (qsize(i) > 0);
            req_data[i*8 +: 8] = (qsize(i) > 0) ? qfront(i) : 8'h00;
        end
    end

    always @(posedge clk) cyc++;

    // ---------------- behavioural model ----------------
    int          m_ptr, m_wait, m_id, m_ops;
    bit          m_resp;
    logic [7:0]  m_in;
    logic [15:0] m_data;
    int          gq[$];

    function automatic int pick(input logic [3:0] v, input int p);
        logic [7:0] dbl;
        dbl = {v, v} >> p;
        for (int k = 0; k < 4; k++) if (dbl[k]) return (p + k) % 4;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_ptr = 0; m_wait = 0; m_id = 0; m_ops = 0;
            m_resp = 0; m_in = 8'h00; m_data = 16'h0000;
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_resp = 0;
                if (m_ops < 65535) m_ops++;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_resp = 1;
                m_data = sq(m_in);
            end
        end else begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) begin
                m_in   = req_data[g*8 +: 8];
                m_id   = g;
                m_ptr  = (g + 1) % 4;
                m_wait = 1;
                gq.push_back(g);
                qpop(g);
            end
        end
    end

    typedef struct { int id; int d; int c; } rsp_t;
    rsp_t rq[$];

    always @(negedge clk) begin
        int  g;
        bit  idle;
        idle = !m_resp && (m_wait == 0);
        g    = pick(req_valid, m_ptr);
        chk("m_req_ready", int'(req_ready), (idle && g >= 0) ? (1 << g) : 0);
        chk("m_busy",      int'(busy),      int'(!idle));
        chk("m_sqrt_in",   int'(sqrt_in),   int'(m_in));
        chk("m_rsp_valid", int'(rsp_valid), int'(m_resp));
        chk("m_rsp_data",  int'(rsp_data),  int'(m_data));
        chk("m_rsp_id",    int'(rsp_id),    m_id);
        chk("m_ops_cnt",   int'(ops_cnt),   m_ops);
        if (rsp_valid && rsp_ready) rq.push_back('{int'(rsp_id), int'(rsp_data), cyc});
    end

    // ---------------- directed helpers ----------------
    task automatic check_reset_outputs(input string nm);
        chk({nm, "_req_ready"}, int'(req_ready), 0);
        chk({nm, "_sqrt_in"},   int'(sqrt_in),   0);
        chk({nm, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({nm, "_rsp_data"},  int'(rsp_data),  0);
        chk({nm, "_rsp_id"},    int'(rsp_id),    0);
        chk({nm, "_busy"},      int'(busy),      0);
        chk({nm, "_ops_cnt"},   int'(ops_cnt),   0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_grants(input int n, input int lim);
        for (int k = 0; k < lim; k++) begin
            if (gq.size() >= n) break;
            @(negedge clk);
        end
        chk("grant_wait", int'(gq.size() >= n), 1);
    endtask

    task automatic wait_rsp_valid(input string nm);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk(nm, int'(rsp_valid), 1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            done = (q0.size() + q1.size() + q2.size() + q3.size() == 0) &&
                   !m_resp && (m_wait == 0) && !rsp_valid;
            if (done) break;
        end
        chk("drain", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        int exp_a[6];
        rst_n = 1'b0; rsp_ready = 1'b0;
        v4 = '0; d4 = '0; rr4 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #3 rst_n = 1'b1;

        // single request
        rsp_ready = 1'b1;
        qpush(0, 8'd16);
        @(posedge clk); @(negedge clk);
        chk("t1_req_ready", int'(req_ready), 1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) break;
            @(negedge clk); n++;
        end
        chk("t1_latency", n, 2);
        chk("t1_rsp_data", int'(rsp_data), 'h0400);
        chk("t1_rsp_id", int'(rsp_id), 0);
        @(negedge clk);
        chk("t1_ops_cnt", int'(ops_cnt), 1);

        // four simultaneous requests from a fresh pointer
        do_reset();
        base = rq.size();
        qpush(0, 8'd0); qpush(1, 8'd2); qpush(2, 8'd16); qpush(3, 8'd255);
        for (int k = 0; k < 40; k++) begin
            if (rq.size() >= base + 4) break;
            @(negedge clk);
        end
        chk("t2_count", int'(rq.size() >= base + 4), 1);
        if (rq.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) chk("t2_id", rq[base+k].id, k);
            chk("t2_d0", rq[base].d,   'h0000);
            chk("t2_d1", rq[base+1].d, 'h016A);
            chk("t2_d2", rq[base+2].d, 'h0400);
            // floor(15.9687 * 256) = 4087
            chk("t2_d3", rq[base+3].d, 'h0FF7);
            for (int k = 0; k < 3; k++) chk("t2_spacing", rq[base+k+1].c - rq[base+k].c, 3);
        end
        drain();

        // backpressure
        #1 rsp_ready = 1'b0;
        qpush(2, 8'd200);
        wait_rsp_valid("t3_wait");
        qpush(0, 8'd9);
        for (int k = 0; k < 5; k++) begin
            chk("t3_rsp_valid", int'(rsp_valid), 1);
            chk("t3_rsp_data", int'(rsp_data), 'h0E24);
            chk("t3_rsp_id", int'(rsp_id), 2);
            chk("t3_req_ready", int'(req_ready), 0);
            chk("t3_busy", int'(busy), 1);
            @(negedge clk);
        end
        chk("t3_still_valid", int'(rsp_valid), 1);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_idle_busy", int'(busy), 0);
        chk("t3_next_grant", int'(req_ready), 1);
        drain();

        // fairness: 1 and 3 alternate
        base = gq.size();
        for (int k = 0; k < 3; k++) begin
            qpush(1, 8'(k + 1)); qpush(3, 8'(k + 5));
        end
        exp_a = '{1, 3, 1, 3, 1, 3};
        wait_grants(base + 6, 60);
        for (int k = 0; k < 6; k++) if (gq.size() > base + k) chk("t4_order", gq[base+k], exp_a[k]);
        drain();

        base = gq.size();
        for (int k = 0; k < 3; k++) begin
            qpush(1, 8'(k + 10)); qpush(3, 8'(k + 20));
        end
        wait_grants(base + 3, 40);
        qpush(0, 8'd30); qpush(0, 8'd31);
        wait_grants(base + 6, 40);
        exp_a = '{1, 3, 1, 3, 0, 1};
        for (int k = 0; k < 6; k++) if (gq.size() > base + k) chk("t4_join", gq[base+k], exp_a[k]);
        drain();

        // four-cycle settle instance
        @(posedge clk); #3 v4 = 4'b0001; d4 = 32'd100;
        @(negedge clk);
        chk("t5_req_ready", int'(ready4), 1);
        @(posedge clk); #1 v4 = 4'b0000;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rv4) break;
            chk("t5_sqrt_in_hold", int'(sin4), 100);
            n++;
        end
        chk("t5_settle", n, 4);
        chk("t5_rsp_valid", int'(rv4), 1);
        chk("t5_rsp_data", int'(rd4), 'h0A00);
        chk("t5_rsp_id", int'(rid4), 0);
        @(negedge clk);
        chk("t5_ops", int'(ops4), 1);

        // reset mid-SETTLE
        qpush(2, 8'd50);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy && !rsp_valid) break;
        end
        chk("t6_in_settle", int'(busy && !rsp_valid), 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("t6_settle_rst");
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_no_spurious", int'(rsp_valid), 0);
        end
        base = gq.size();
        qpush(1, 8'd4); qpush(3, 8'd9);
        wait_grants(base + 1, 20);
        if (gq.size() > base) chk("t6_first_grant", gq[base], 1);
        drain();

        // reset mid-RESP
        #1 rsp_ready = 1'b0;
        qpush(2, 8'd81);
        wait_rsp_valid("t7_wait");
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("t7_resp_rst");
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t7_no_spurious", int'(rsp_valid), 0);
        end
        #1 rsp_ready = 1'b1;
        base = gq.size();
        qpush(1, 8'd1); qpush(3, 8'd2);
        wait_grants(base + 1, 20);
        if (gq.size() > base) chk("t7_first_grant", gq[base], 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
